// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter for the data-memory window: address decode, round-robin
// grant, fixed-wait-state memory sequencing and error acknowledge.
module mem_bus_arbiter #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_4B00,
  parameter logic [31:0] WINDOW_SIZE = 32'h0000_0400,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        M0_REQ,
  input  logic        M0_WE,
  input  logic [31:0] M0_ADDR,
  input  logic [31:0] M0_WDATA,
  output logic [31:0] M0_RDATA,
  output logic        M0_ACK,
  output logic        M0_ERR,
  input  logic        M1_REQ,
  input  logic        M1_WE,
  input  logic [31:0] M1_ADDR,
  input  logic [31:0] M1_WDATA,
  output logic [31:0] M1_RDATA,
  output logic        M1_ACK,
  output logic        M1_ERR,
  output logic        MEM_CS,
  output logic        MEM_WE,
  output logic [31:0] MEM_ADDR,
  output logic [31:0] MEM_WDATA,
  input  logic [31:0] MEM_RDATA
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [3:0] LP_WAIT = 4'(WAIT_CYCLES);

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_last;   // 0 = M0 granted last, 1 = M1
  logic        r_sel;
  logic        r_we;

  logic        w_any;
  logic        w_sel;
  logic        w_we;
  logic [31:0] w_addr;
  logic [31:0] w_wdata;
  logic [31:0] w_off;
  logic        w_in_win;

  // Contention goes to whichever master did not win the previous grant.
  assign w_any    = M0_REQ | M1_REQ;
  assign w_sel    = M1_REQ & (~M0_REQ | ~r_last);
  assign w_we     = w_sel ? M1_WE    : M0_WE;
  assign w_addr   = w_sel ? M1_ADDR  : M0_ADDR;
  assign w_wdata  = w_sel ? M1_WDATA : M0_WDATA;
  assign w_off    = w_addr - BASE_ADDR;
  assign w_in_win = (w_addr >= BASE_ADDR) && (w_off < WINDOW_SIZE);

  // NOTE: every register here, outputs included, uses non-blocking assignment so
  // all of them update together from pre-edge values; blocking would make the
  // result depend on statement order.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_last    <= 1'b1;
      r_sel     <= 1'b0;
      r_we      <= 1'b0;
      M0_RDATA  <= '0;
      M0_ACK    <= 1'b0;
      M0_ERR    <= 1'b0;
      M1_RDATA  <= '0;
      M1_ACK    <= 1'b0;
      M1_ERR    <= 1'b0;
      MEM_CS    <= 1'b0;
      MEM_WE    <= 1'b0;
      MEM_ADDR  <= '0;
      MEM_WDATA <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_sel  <= w_sel;
            r_last <= w_sel;
            r_we   <= w_we;
            r_cnt  <= '0;
            if (w_in_win) begin
              r_state   <= ACCESS;
              MEM_CS    <= 1'b1;
              MEM_WE    <= w_we;
              MEM_ADDR  <= w_off;
              MEM_WDATA <= w_wdata;
            end else begin
              r_state <= RESP;
            end
          end
        end

        ACCESS: begin
          if (r_cnt == LP_WAIT) begin
            if (!r_we) begin
              if (r_sel) M1_RDATA <= MEM_RDATA;
              else       M0_RDATA <= MEM_RDATA;
            end
            M0_ACK    <= ~r_sel;
            M1_ACK    <= r_sel;
            MEM_CS    <= 1'b0;
            MEM_WE    <= 1'b0;
            MEM_ADDR  <= '0;
            MEM_WDATA <= '0;
            r_state   <= RESP;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end

        RESP: begin
          if (M0_ACK | M1_ACK) begin
            M0_ACK  <= 1'b0;
            M0_ERR  <= 1'b0;
            M1_ACK  <= 1'b0;
            M1_ERR  <= 1'b0;
            r_state <= IDLE;
          end else begin
            // Only an out-of-window grant arrives here without an ACK pending.
            M0_ACK <= ~r_sel;
            M0_ERR <= ~r_sel;
            M1_ACK <= r_sel;
            M1_ERR <= r_sel;
            if (!r_we) begin
              if (r_sel) M1_RDATA <= '0;
              else       M0_RDATA <= '0;
            end
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios plus random
// two-master traffic against a transaction-level schedule model.
module tb_mem_bus_arbiter;

  localparam logic [31:0] BASE = 32'h0000_4B00;
  localparam logic [31:0] SIZE = 32'h0000_0400;
  localparam int          W    = 2;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  logic        CLK = 1'b0;
  logic        RST;
  logic        M0_REQ, M0_WE, M1_REQ, M1_WE;
  logic [31:0] M0_ADDR, M0_WDATA, M1_ADDR, M1_WDATA;
  logic [31:0] M0_RDATA, M1_RDATA, MEM_ADDR, MEM_WDATA, MEM_RDATA;
  logic        M0_ACK, M0_ERR, M1_ACK, M1_ERR, MEM_CS, MEM_WE;

  logic [31:0] z_m0_rdata, z_m1_rdata, z_mem_addr, z_mem_wdata;
  logic        z_m0_ack, z_m0_err, z_m1_ack, z_m1_err, z_mem_cs, z_mem_we;

  logic        rd_fixed_en = 1'b1;
  logic [31:0] rd_fixed    = 32'h0;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic [31:0] mem_word(input logic [31:0] off);
    return {off[15:0] ^ 16'hA5C3, ~off[15:0]};
  endfunction

  assign MEM_RDATA = rd_fixed_en ? rd_fixed : mem_word(MEM_ADDR);

  mem_bus_arbiter #(.BASE_ADDR(BASE), .WINDOW_SIZE(SIZE), .WAIT_CYCLES(W)) dut (
    .CLK(CLK), .RST(RST),
    .M0_REQ(M0_REQ), .M0_WE(M0_WE), .M0_ADDR(M0_ADDR), .M0_WDATA(M0_WDATA),
    .M0_RDATA(M0_RDATA), .M0_ACK(M0_ACK), .M0_ERR(M0_ERR),
    .M1_REQ(M1_REQ), .M1_WE(M1_WE), .M1_ADDR(M1_ADDR), .M1_WDATA(M1_WDATA),
    .M1_RDATA(M1_RDATA), .M1_ACK(M1_ACK), .M1_ERR(M1_ERR),
    .MEM_CS(MEM_CS), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA),
    .MEM_RDATA(MEM_RDATA)
  );

  mem_bus_arbiter #(.BASE_ADDR(BASE), .WINDOW_SIZE(SIZE), .WAIT_CYCLES(0)) dut0 (
    .CLK(CLK), .RST(RST),
    .M0_REQ(M0_REQ), .M0_WE(M0_WE), .M0_ADDR(M0_ADDR), .M0_WDATA(M0_WDATA),
    .M0_RDATA(z_m0_rdata), .M0_ACK(z_m0_ack), .M0_ERR(z_m0_err),
    .M1_REQ(M1_REQ), .M1_WE(M1_WE), .M1_ADDR(M1_ADDR), .M1_WDATA(M1_WDATA),
    .M1_RDATA(z_m1_rdata), .M1_ACK(z_m1_ack), .M1_ERR(z_m1_err),
    .MEM_CS(z_mem_cs), .MEM_WE(z_mem_we), .MEM_ADDR(z_mem_addr), .MEM_WDATA(z_mem_wdata),
    .MEM_RDATA(MEM_RDATA)
  );

  // Master-side state and transaction-level model of the shared window.
  req_t        pend [2];
  bit          active [2];
  logic [31:0] mrdata [2];
  req_t        q0 [$];
  req_t        q1 [$];
  bit          busy;
  int          serv, last, cs_start, cs_end, ack_edge, next_free;
  bit          s_in;
  req_t        s_req;

  // Observation logs for the directed scenarios.
  int          cs_cycles, we_cycles, two_ack;
  bit          prev_cs;
  int          acklog [$];
  logic        errlog [$];
  logic [31:0] cs_addr_log [$];
  logic [31:0] cs_wd_log [$];

  function automatic bit in_win(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + SIZE);
  endfunction

  function automatic logic [31:0] model_word(input logic [31:0] off);
    return rd_fixed_en ? rd_fixed : mem_word(off);
  endfunction

  function automatic req_t rand_req();
    req_t r;
    r.we    = 1'($urandom_range(1, 0));
    r.wdata = $urandom;
    case ($urandom_range(3, 0))
      0, 1:    r.addr = BASE + $urandom_range(int'(SIZE) - 1, 0);
      2:       r.addr = $urandom;
      default: begin
        case ($urandom_range(3, 0))
          0:       r.addr = BASE - 1;
          1:       r.addr = BASE;
          2:       r.addr = BASE + SIZE - 1;
          default: r.addr = BASE + SIZE;
        endcase
      end
    endcase
    return r;
  endfunction

  task automatic apply_inputs();
    M0_REQ = active[0]; M0_WE = pend[0].we; M0_ADDR = pend[0].addr; M0_WDATA = pend[0].wdata;
    M1_REQ = active[1]; M1_WE = pend[1].we; M1_ADDR = pend[1].addr; M1_WDATA = pend[1].wdata;
  endtask

  task automatic clear_logs();
    cs_cycles = 0; we_cycles = 0; two_ack = 0;
    acklog.delete(); errlog.delete(); cs_addr_log.delete(); cs_wd_log.delete();
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b0;
    for (int m = 0; m < 2; m++) begin
      active[m] = 1'b0; mrdata[m] = '0; pend[m] = '0;
    end
    q0.delete(); q1.delete();
    apply_inputs();
    busy = 1'b0; last = 1; prev_cs = 1'b0;
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    next_free = cyc + 1;
  endtask

  // Called at each falling edge: check the cycle, update masters, predict grants.
  task automatic step(input bit rnd);
    int          n;
    bit          exp_cs, exp_we, ea0, ea1;
    logic [31:0] exp_addr, exp_wd;
    n = cyc;

    if (MEM_CS === 1'b1) begin
      cs_cycles++;
      if (MEM_WE === 1'b1) we_cycles++;
      if (!prev_cs) begin cs_addr_log.push_back(MEM_ADDR); cs_wd_log.push_back(MEM_WDATA); end
    end
    prev_cs = (MEM_CS === 1'b1);
    if (M0_ACK === 1'b1 && M1_ACK === 1'b1) two_ack++;
    if (M0_ACK === 1'b1) begin acklog.push_back(0); errlog.push_back(M0_ERR); end
    if (M1_ACK === 1'b1) begin acklog.push_back(1); errlog.push_back(M1_ERR); end

    exp_cs   = busy && s_in && (n >= cs_start) && (n <= cs_end);
    exp_we   = exp_cs && s_req.we;
    exp_addr = exp_cs ? s_req.addr - BASE : 32'h0;
    exp_wd   = exp_cs ? s_req.wdata : 32'h0;
    total++;
    if ({MEM_CS, MEM_WE, MEM_ADDR, MEM_WDATA} !== {exp_cs, exp_we, exp_addr, exp_wd}) begin
      bad++;
      $display("FAIL mem_bus cyc=%0d got cs=%b we=%b addr=%h wd=%h want cs=%b we=%b addr=%h wd=%h",
               n, MEM_CS, MEM_WE, MEM_ADDR, MEM_WDATA, exp_cs, exp_we, exp_addr, exp_wd);
    end

    ea0 = busy && (serv == 0) && (n == ack_edge);
    ea1 = busy && (serv == 1) && (n == ack_edge);
    total++;
    if ({M0_ACK, M0_ERR, M1_ACK, M1_ERR} !== {ea0, ea0 && !s_in, ea1, ea1 && !s_in}) begin
      bad++;
      $display("FAIL ack_err cyc=%0d got m0=%b/%b m1=%b/%b want m0=%b/%b m1=%b/%b",
               n, M0_ACK, M0_ERR, M1_ACK, M1_ERR, ea0, ea0 && !s_in, ea1, ea1 && !s_in);
    end

    if (busy && n == ack_edge) begin
      if (!s_req.we) mrdata[serv] = s_in ? model_word(s_req.addr - BASE) : 32'h0;
      active[serv] = 1'b0;
      busy = 1'b0;
    end
    total++;
    if ({M0_RDATA, M1_RDATA} !== {mrdata[0], mrdata[1]}) begin
      bad++;
      $display("FAIL rdata cyc=%0d got m0=%h m1=%h want m0=%h m1=%h",
               n, M0_RDATA, M1_RDATA, mrdata[0], mrdata[1]);
    end

    for (int m = 0; m < 2; m++) begin
      if (!active[m]) begin
        if (rnd) begin
          if ($urandom_range(1, 0) == 1) begin pend[m] = rand_req(); active[m] = 1'b1; end
        end else if (m == 0 && q0.size() > 0) begin
          pend[0] = q0.pop_front(); active[0] = 1'b1;
        end else if (m == 1 && q1.size() > 0) begin
          pend[1] = q1.pop_front(); active[1] = 1'b1;
        end
      end
    end

    if (!busy && (n + 1 >= next_free) && (active[0] || active[1])) begin
      if (active[0] && active[1]) serv = (last == 0) ? 1 : 0;
      else                        serv = active[1] ? 1 : 0;
      last      = serv;
      busy      = 1'b1;
      s_req     = pend[serv];
      s_in      = in_win(s_req.addr);
      cs_start  = n + 1;
      cs_end    = n + 1 + W;
      ack_edge  = s_in ? n + 2 + W : n + 2;
      next_free = ack_edge + 2;
    end
    apply_inputs();
  endtask

  task automatic run(input bit rnd, input int max_cycles);
    int k = 0;
    do begin
      @(negedge CLK);
      step(rnd);
      k++;
    end while (k < max_cycles &&
               (rnd || busy || active[0] || active[1] || q0.size() > 0 || q1.size() > 0));
    if (!rnd) begin
      total++;
      if (busy || active[0] || active[1]) begin
        bad++;
        $display("FAIL run_timeout got pending=1 want pending=0 after %0d cycles", k);
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      total++;
      if ({M0_ACK, M0_ERR, M1_ACK, M1_ERR, MEM_CS, MEM_WE, MEM_ADDR, MEM_WDATA, M0_RDATA, M1_RDATA,
           z_m0_ack, z_m1_ack, z_mem_cs} !== '0) begin
        bad++;
        $display("FAIL reset_idle cycle=%0d got cs=%b addr=%h ack=%b%b want all zero",
                 i, MEM_CS, MEM_ADDR, M0_ACK, M1_ACK);
      end
    end
  endtask

  task automatic test_read();
    clear_logs();
    rd_fixed_en = 1'b1; rd_fixed = 32'hDEAD_BEEF;
    q0.push_back('{we: 1'b0, addr: 32'h4B00, wdata: 32'h0});
    run(1'b0, 50);
    total++;
    if (cs_cycles != 3 || cs_addr_log.size() != 1 || cs_addr_log[0] !== 32'h0) begin
      bad++;
      $display("FAIL read_cs got cycles=%0d runs=%0d want cycles=3 runs=1 addr=0",
               cs_cycles, cs_addr_log.size());
    end
    total++;
    if (M0_RDATA !== 32'hDEAD_BEEF || acklog.size() != 1 || errlog[0] !== 1'b0) begin
      bad++;
      $display("FAIL read_data got rdata=%h acks=%0d want rdata=deadbeef acks=1 err=0",
               M0_RDATA, acklog.size());
    end
  endtask

  task automatic test_boundary();
    logic [31:0] addrs [4] = '{32'h4AFF, 32'h4B00, 32'h4EFF, 32'h4F00};
    logic        errs  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    clear_logs();
    rd_fixed_en = 1'b0;
    for (int i = 0; i < 4; i++) q1.push_back('{we: 1'b0, addr: addrs[i], wdata: 32'h0});
    run(1'b0, 100);
    total++;
    if (errlog.size() != 4) begin
      bad++;
      $display("FAIL boundary_acks got %0d want 4", errlog.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (errlog[i] !== errs[i] || acklog[i] != 1) begin
          bad++;
          $display("FAIL boundary_err addr=%h got err=%b master=%0d want err=%b master=1",
                   addrs[i], errlog[i], acklog[i], errs[i]);
        end
      end
    end
    total++;
    if (cs_cycles != 6 || cs_addr_log.size() != 2 ||
        cs_addr_log[0] !== 32'h0 || cs_addr_log[1] !== 32'h3FF) begin
      bad++;
      $display("FAIL boundary_cs got cycles=%0d runs=%0d want cycles=6 addrs=0,3ff",
               cs_cycles, cs_addr_log.size());
    end
  endtask

  task automatic test_back_to_back();
    clear_logs();
    for (int i = 0; i < 4; i++) begin
      q0.push_back('{we: 1'b1, addr: BASE + 32'(16 * i), wdata: 32'h1000_0000 + 32'(i)});
      q1.push_back('{we: 1'b1, addr: BASE + 32'(16 * i + 4), wdata: 32'h2000_0000 + 32'(i)});
    end
    run(1'b0, 200);
    total++;
    if (acklog.size() != 8 || cs_wd_log.size() != 8 || two_ack != 0) begin
      bad++;
      $display("FAIL b2b_count got acks=%0d runs=%0d double=%0d want 8 8 0",
               acklog.size(), cs_wd_log.size(), two_ack);
    end else begin
      for (int k = 0; k < 8; k++) begin
        logic [31:0] ew;
        ew = ((k % 2) == 0 ? 32'h1000_0000 : 32'h2000_0000) + 32'(k / 2);
        total++;
        if (acklog[k] != (k % 2) || cs_wd_log[k] !== ew) begin
          bad++;
          $display("FAIL b2b_order slot=%0d got master=%0d wdata=%h want master=%0d wdata=%h",
                   k, acklog[k], cs_wd_log[k], k % 2, ew);
        end
      end
    end
  endtask

  task automatic test_write();
    clear_logs();
    rd_fixed_en = 1'b1; rd_fixed = 32'hA5A5_0F0F;
    q1.push_back('{we: 1'b0, addr: 32'h4B04, wdata: 32'h0});
    q1.push_back('{we: 1'b1, addr: 32'h4C10, wdata: 32'h1234_5678});
    run(1'b0, 60);
    total++;
    if (cs_cycles != 6 || we_cycles != 3 || cs_addr_log.size() != 2 ||
        cs_addr_log[1] !== 32'h110 || cs_wd_log[1] !== 32'h1234_5678) begin
      bad++;
      $display("FAIL write_cs got cs=%0d we=%0d runs=%0d want cs=6 we=3 addr=110 wd=12345678",
               cs_cycles, we_cycles, cs_addr_log.size());
    end
    total++;
    if (M1_RDATA !== 32'hA5A5_0F0F) begin
      bad++;
      $display("FAIL write_rdata_hold got %h want a5a50f0f", M1_RDATA);
    end
  endtask

  task automatic test_wait0();
    int cs_cnt = 0, first_cs = -1, last_cs = -1, ack_at = -1;
    logic [31:0] rd = '0;
    logic        er = 1'b1;
    do_reset();
    rd_fixed_en = 1'b1; rd_fixed = 32'h0BAD_F00D;
    @(negedge CLK);
    M0_REQ = 1'b1; M0_WE = 1'b0; M0_ADDR = 32'h4B00; M0_WDATA = 32'h0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge CLK);
      if (z_mem_cs === 1'b1) begin
        cs_cnt++; last_cs = i;
        if (first_cs < 0) first_cs = i;
      end
      if (z_m0_ack === 1'b1 && ack_at < 0) begin
        ack_at = i; rd = z_m0_rdata; er = z_m0_err; M0_REQ = 1'b0;
      end
    end
    total++;
    if (cs_cnt != 1 || first_cs != 1) begin
      bad++;
      $display("FAIL wait0_cs got cycles=%0d first=%0d want cycles=1 first=1", cs_cnt, first_cs);
    end
    total++;
    if (ack_at != last_cs + 1 || rd !== 32'h0BAD_F00D || er !== 1'b0) begin
      bad++;
      $display("FAIL wait0_ack got at=%0d rdata=%h err=%b want at=%0d rdata=0badf00d err=0",
               ack_at, rd, er, last_cs + 1);
    end
    do_reset();
  endtask

  task automatic test_random();
    int n0 = 0, n1 = 0;
    clear_logs();
    rd_fixed_en = 1'b0;
    run(1'b1, 3000);
    foreach (acklog[k]) if (acklog[k] == 0) n0++; else n1++;
    total++;
    if (n0 < 20 || n1 < 20 || two_ack != 0) begin
      bad++;
      $display("FAIL random_traffic got m0=%0d m1=%0d double=%0d want >=20 each, 0 double",
               n0, n1, two_ack);
    end
  endtask

  task automatic test_reset_mid_access();
    bit seen = 1'b0;
    do_reset();
    clear_logs();
    q0.push_back('{we: 1'b0, addr: 32'h4B20, wdata: 32'h0});
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge CLK);
      step(1'b0);
      seen = (MEM_CS === 1'b1);
    end
    #1 RST = 1'b0;
    active[0] = 1'b0;
    apply_inputs();
    #1;
    total++;
    if (!seen || MEM_CS !== 1'b0 || MEM_ADDR !== 32'h0 || M0_ACK !== 1'b0) begin
      bad++;
      $display("FAIL abort_now got seen=%b cs=%b addr=%h ack=%b want seen=1 cs=0 addr=0 ack=0",
               seen, MEM_CS, MEM_ADDR, M0_ACK);
    end
    @(negedge CLK);
    RST = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      total++;
      if ({M0_ACK, M1_ACK, MEM_CS} !== 3'b000) begin
        bad++;
        $display("FAIL abort_no_ack cycle=%0d got ack=%b%b cs=%b want 000", i, M0_ACK, M1_ACK, MEM_CS);
      end
    end
  endtask

  initial begin
    RST = 1'b0;
    for (int m = 0; m < 2; m++) begin active[m] = 1'b0; pend[m] = '0; mrdata[m] = '0; end
    apply_inputs();
    test_reset();
    test_read();
    test_boundary();
    test_back_to_back();
    test_write();
    test_wait0();
    test_random();
    test_reset_mid_access();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
